counter_decoder: RTL

//  Receiving end of the 8-bit up/down counter stream: samples a counter value each valid cycle
//  and recovers the control that produced it (step up, step down, paused, parallel load).

---
 rtl/counter_pkg.sv | 20 ++
 rtl/counter_decoder_sat_counter.sv | 20 ++
 rtl/counter_decoder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter stream decoder.
// Holds the event and state enums plus width defaults used by the decoder slice.
package counter_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAT_W = 16;

    typedef enum logic [1:0] {
        EVT_HOLD,
        EVT_UP,
        EVT_DOWN,
        EVT_JUMP
    } cnt_evt_t;

    typedef enum logic {
        ST_EMPTY,
        ST_TRACK
    } dec_state_t;

endpackage

// File: rtl/counter_decoder_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
// Ports: clk, reset (sync, high), inc (count enable), q (count value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/counter_decoder.sv
// Monitor for an up/down counter stream: recovers step/hold/load per sample.
// Ports: clk, reset (sync, high), valid, count_in, jump_allowed, clr_err in;
//   evt_valid, dir_out, pause_out, load_out, wrap_out, err, and the four
//   saturating stat counters out. Stats exist only with COUNTER_DECODER_STATS_EN,
//   otherwise the stat ports are tied to zero.
module counter_decoder
    import counter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAT_W = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              jump_allowed,
    input  logic              clr_err,
    output logic              evt_valid,
    output logic              dir_out,
    output logic              pause_out,
    output logic              load_out,
    output logic              wrap_out,
    output logic              err,
    output logic [STAT_W-1:0] up_cnt,
    output logic [STAT_W-1:0] down_cnt,
    output logic [STAT_W-1:0] hold_cnt,
    output logic [STAT_W-1:0] load_cnt
);

    if (WIDTH < 2) begin : g_bad_width
        $error("counter_decoder: WIDTH must be >= 2");
    end

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    dec_state_t       state_q;
    dec_state_t       state_d;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] delta;
    cnt_evt_t         evt;
    logic             accept;
    logic             err_set;

    // Only samples taken while tracking produce an event; the first one seeds.
    assign accept  = valid && (state_q == ST_TRACK);
    assign delta   = count_in - prev_q;
    assign err_set = accept && (evt == EVT_JUMP) && !jump_allowed;

    always_comb begin
        evt = EVT_JUMP;
        unique case (1'b1)
            (delta == ONE): evt = EVT_UP;
            (delta == '1):  evt = EVT_DOWN;
            (delta == '0):  evt = EVT_HOLD;
            default:        evt = EVT_JUMP;
        endcase
    end

    always_comb begin
        state_d = state_q;
        if (valid && (state_q == ST_EMPTY)) begin
            state_d = ST_TRACK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            evt_valid <= 1'b0;
            dir_out   <= 1'b0;
            pause_out <= 1'b0;
            load_out  <= 1'b0;
            wrap_out  <= 1'b0;
        end else begin
            evt_valid <= accept;
            if (valid) begin
                prev_q <= count_in;
            end
            if (accept) begin
                pause_out <= (evt == EVT_HOLD);
                load_out  <= (evt == EVT_JUMP);
                wrap_out  <= ((evt == EVT_UP) && (count_in == '0))
                          || ((evt == EVT_DOWN) && (count_in == '1));
                if (evt == EVT_UP) begin
                    dir_out <= 1'b1;
                end else if (evt == EVT_DOWN) begin
                    dir_out <= 1'b0;
                end
            end
        end
    end

    // Set wins over clear so an illegal jump is never lost to a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

`ifdef COUNTER_DECODER_STATS_EN
    sat_counter #(.W(STAT_W)) u_up_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && (evt == EVT_UP)),
        .q     (up_cnt)
    );

    sat_counter #(.W(STAT_W)) u_down_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && (evt == EVT_DOWN)),
        .q     (down_cnt)
    );

    sat_counter #(.W(STAT_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && (evt == EVT_HOLD)),
        .q     (hold_cnt)
    );

    sat_counter #(.W(STAT_W)) u_load_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (accept && (evt == EVT_JUMP)),
        .q     (load_cnt)
    );
`else
    assign up_cnt   = '0;
    assign down_cnt = '0;
    assign hold_cnt = '0;
    assign load_cnt = '0;
`endif

endmodule
